// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB table generator: FSM states, default sizes,
// and the helper that derives the table depth from the lookup digit width.
// No ports; imported by xpb_mod_add_step and xpb_table_gen.
package xpb_pkg;

    localparam int XPB_DATA_W = 1024;
    localparam int XPB_IDX_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GEN  = 2'd2,
        ST_DONE = 2'd3
    } xpb_state_e;

    function automatic int xpb_depth(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage

// File: rtl/xpb_mod_add_step.sv
// One modular accumulation step: nxt_o = (acc_i + base_i) mod mod_i.
// Ports: acc_i, base_i, mod_i in (DATA_W each), nxt_o out (DATA_W); purely combinational.
// Caller guarantees acc_i < mod_i and base_i < mod_i, so one conditional subtract is enough.
module xpb_mod_add_step
    import xpb_pkg::*;
#(
    parameter int DATA_W = XPB_DATA_W
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] base_i,
    input  logic [DATA_W-1:0] mod_i,
    output logic [DATA_W-1:0] nxt_o
);

    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] mod_ext_w;
    logic            ge_w;

    // The extra carry bit keeps acc+base exact before the compare.
    assign sum_w     = {1'b0, acc_i} + {1'b0, base_i};
    assign mod_ext_w = {1'b0, mod_i};
    assign ge_w      = (sum_w >= mod_ext_w);
    // After the subtract the result is < mod_i, so the carry bit is always zero.
    assign nxt_o     = DATA_W'(ge_w ? (sum_w - mod_ext_w) : sum_w);

endmodule

// File: rtl/xpb_table_gen.sv
// Builds entry[j] = j*B mod M (j = 0..2^IDX_W-1) one entry per cycle, then serves
// NUM_CH independent 1-cycle registered lookups gated by table_ready.
// Ports: clk/rst_n; init_start/init_base/init_mod in, init_busy/init_done/init_err/
// table_ready out; lk_valid/lk_idx in, lk_data/lk_data_valid out (channel-packed).
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int DATA_W = XPB_DATA_W,
    parameter int IDX_W  = XPB_IDX_W,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_start,
    input  logic [DATA_W-1:0]        init_base,
    input  logic [DATA_W-1:0]        init_mod,
    output logic                     init_busy,
    output logic                     init_done,
    output logic                     init_err,
    output logic                     table_ready,
    input  logic [NUM_CH-1:0]        lk_valid,
    input  logic [NUM_CH*IDX_W-1:0]  lk_idx,
    output logic [NUM_CH*DATA_W-1:0] lk_data,
    output logic [NUM_CH-1:0]        lk_data_valid
);

    localparam int DEPTH = xpb_depth(IDX_W);

    xpb_state_e          state_q;
    logic [DATA_W-1:0]   base_q;
    logic [DATA_W-1:0]   mod_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_d;
    logic [IDX_W-1:0]    j_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                ready_q;
    logic [NUM_CH*DATA_W-1:0] lk_data_q;
    logic [NUM_CH-1:0]   lk_vld_q;

    // Table storage is deliberately not reset; every read is gated by ready_q.
    logic [DATA_W-1:0]   tbl_q [DEPTH];
    logic                wr_en_w;
    logic [IDX_W-1:0]    wr_idx_w;
    logic [DATA_W-1:0]   wr_dat_w;

    xpb_mod_add_step #(.DATA_W(DATA_W)) u_step (
        .acc_i  (acc_q),
        .base_i (base_q),
        .mod_i  (mod_q),
        .nxt_o  (acc_d)
    );

    // LOAD writes entry 0 = 0; GEN writes the running accumulator at j.
    assign wr_en_w  = (state_q == ST_LOAD) || (state_q == ST_GEN);
    assign wr_idx_w = (state_q == ST_LOAD) ? '0 : j_q;
    assign wr_dat_w = (state_q == ST_LOAD) ? '0 : acc_d;

    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            tbl_q[wr_idx_w] <= wr_dat_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            mod_q   <= '0;
            acc_q   <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (init_start) begin
                        // Either outcome invalidates the current table.
                        ready_q <= 1'b0;
                        if ((init_mod == '0) || (init_base >= init_mod)) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q  <= init_base;
                            mod_q   <= init_mod;
                            busy_q  <= 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    acc_q   <= '0;
                    j_q     <= IDX_W'(1);
                    state_q <= ST_GEN;
                end
                ST_GEN: begin
                    acc_q <= acc_d;
                    j_q   <= j_q + IDX_W'(1);
                    if (&j_q) begin
                        // Last entry lands on this edge, so the table is whole in DONE.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Lookups sample ready_q before any start in the same cycle takes effect,
    // so a lookup alongside an accepted start is served from the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_data_q <= '0;
            lk_vld_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                lk_vld_q[c] <= lk_valid[c] && ready_q;
                if (lk_valid[c] && ready_q) begin
                    lk_data_q[c*DATA_W +: DATA_W] <= tbl_q[lk_idx[c*IDX_W +: IDX_W]];
                end
            end
        end
    end

    assign init_busy     = busy_q;
    assign init_done     = done_q;
    assign init_err      = err_q;
    assign table_ready   = ready_q;
    assign lk_data       = lk_data_q;
    assign lk_data_valid = lk_vld_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Randomized self-checking bench for xpb_table_gen against a j*B mod M reference model.
// Latency: checks 1-cycle lookups and a (DEPTH+1)-cycle build from accepted start to done.
// Backpressure: none in the design; the bench drives lookups freely, including during builds.
module tb_xpb_table_gen;

    localparam int DATA_W = 1024;
    localparam int IDX_W  = 5;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int LKW    = NUM_CH * IDX_W;
    localparam int PW     = DATA_W + 8;

    logic                     clk;
    logic                     rst_n;
    logic                     init_start;
    logic [DATA_W-1:0]        init_base;
    logic [DATA_W-1:0]        init_mod;
    logic                     init_busy;
    logic                     init_done;
    logic                     init_err;
    logic                     table_ready;
    logic [NUM_CH-1:0]        lk_valid;
    logic [LKW-1:0]           lk_idx;
    logic [NUM_CH*DATA_W-1:0] lk_data;
    logic [NUM_CH-1:0]        lk_data_valid;

    xpb_table_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_start    (init_start),
        .init_base     (init_base),
        .init_mod      (init_mod),
        .init_busy     (init_busy),
        .init_done     (init_done),
        .init_err      (init_err),
        .table_ready   (table_ready),
        .lk_valid      (lk_valid),
        .lk_idx        (lk_idx),
        .lk_data       (lk_data),
        .lk_data_valid (lk_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state: expected table contents, readiness and held lookup data.
    logic [DATA_W-1:0] ref_tbl [DEPTH];
    logic              exp_ready;
    logic [DATA_W-1:0] exp_d [NUM_CH];

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_entry(input int j, input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] m);
        logic [PW-1:0] p;
        p = PW'(j) * {8'b0, b};
        p = p % {8'b0, m};
        return p[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] ch_data(input int c);
        return lk_data[c*DATA_W +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one lookup cycle, predict from the model, then check every channel.
    task automatic do_lk(input logic [NUM_CH-1:0] v, input logic [LKW-1:0] idx);
        logic [NUM_CH-1:0] exp_v;
        lk_valid = v;
        lk_idx   = idx;
        for (int c = 0; c < NUM_CH; c++) begin
            if (v[c] && exp_ready) begin
                exp_d[c] = ref_tbl[idx[c*IDX_W +: IDX_W]];
                exp_v[c] = 1'b1;
            end else begin
                exp_v[c] = 1'b0;
            end
        end
        tick();
        lk_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("lk_vld%0d", c), lk_data_valid[c], exp_v[c]);
            chk($sformatf("lk_dat%0d", c), ch_data(c), exp_d[c]);
        end
    endtask

    // Full build; optionally with lookups running throughout and a stray start at poke_cyc.
    task automatic build(input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] m,
                         input bit lk_during, input int poke_cyc);
        int cyc;
        int busy_cnt;
        bit err_seen;
        bit gen_v;
        init_base  = b;
        init_mod   = m;
        init_start = 1'b1;
        if (lk_during) do_lk('1, {NUM_CH{IDX_W'(2)}});
        else tick();
        init_start = 1'b0;
        exp_ready  = 1'b0;
        cyc = 1; busy_cnt = 0; err_seen = 0; gen_v = 0;
        chk("bld_busy_start", init_busy, 1'b1);
        chk("bld_ready_drop", table_ready, 1'b0);
        while (init_done !== 1'b1 && cyc < 200) begin
            if (init_busy) busy_cnt++;
            init_start = (cyc == poke_cyc);
            init_base  = (cyc == poke_cyc) ? '0 : b;
            if (lk_during) begin
                lk_valid = '1;
                lk_idx   = LKW'($urandom);
            end
            tick();
            cyc++;
            init_start = 1'b0;
            if (init_err) err_seen = 1;
            if (lk_data_valid != '0) gen_v = 1;
        end
        lk_valid = '0;
        chk("bld_done_lat", cyc, DEPTH + 1);
        chk("bld_busy_cycles", busy_cnt, DEPTH);
        chk("bld_ready_at_done", table_ready, 1'b1);
        chk("bld_busy_at_done", init_busy, 1'b0);
        chk("bld_no_err", err_seen, 1'b0);
        if (lk_during) chk("bld_gen_lk_vld", gen_v, 1'b0);
        for (int j = 0; j < DEPTH; j++) ref_tbl[j] = ref_entry(j, b, m);
        exp_ready = 1'b1;
        tick();
        chk("bld_done_pulse", init_done, 1'b0);
    endtask

    task automatic reject(input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] m);
        logic exp_e;
        exp_e      = (m == '0) || (b >= m);
        init_base  = b;
        init_mod   = m;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        exp_ready  = 1'b0;
        chk("rej_err", init_err, exp_e);
        chk("rej_ready", table_ready, 1'b0);
        chk("rej_busy", init_busy, 1'b0);
        tick();
        chk("rej_err_pulse", init_err, 1'b0);
        chk("rej_no_gen", init_busy, 1'b0);
    endtask

    // Build, read back every entry across all channels, then random lookups.
    task automatic full_check(input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] m);
        logic [LKW-1:0] idx;
        build(b, m, 1'b0, -1);
        for (int p = 0; p < DEPTH / NUM_CH; p++) begin
            for (int c = 0; c < NUM_CH; c++) idx[c*IDX_W +: IDX_W] = IDX_W'(p * NUM_CH + c);
            do_lk('1, idx);
        end
        for (int k = 0; k < 20; k++) do_lk(NUM_CH'($urandom), LKW'($urandom));
    endtask

    logic [DATA_W-1:0] known [8];
    logic [DATA_W-1:0] rm;
    logic [DATA_W-1:0] rb;
    logic [LKW-1:0]    idx_v;

    initial begin
        known[0] = 0; known[1] = 5; known[2] = 10; known[3] = 2;
        known[4] = 7; known[5] = 12; known[6] = 4; known[7] = 9;
        rst_n = 1'b0; init_start = 1'b0; init_base = '0; init_mod = '0;
        lk_valid = '0; lk_idx = '0;
        exp_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) exp_d[c] = '0;
        for (int j = 0; j < DEPTH; j++) ref_tbl[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", init_busy, 1'b0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_err", init_err, 1'b0);
        chk("rst_ready", table_ready, 1'b0);
        chk("rst_lk_vld", lk_data_valid, '0);
        for (int c = 0; c < NUM_CH; c++) chk("rst_lk_dat", ch_data(c), '0);
        rst_n = 1'b1;
        do_lk('1, LKW'($urandom));

        // Small-modulus build with known values.
        build(1024'd5, 1024'd13, 1'b0, -1);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NUM_CH; c++) idx_v[c*IDX_W +: IDX_W] = IDX_W'(p * NUM_CH + c);
            do_lk('1, idx_v);
            for (int c = 0; c < NUM_CH; c++) chk("known_val", ch_data(c), known[p*NUM_CH + c]);
        end

        // All channels at once, including a shared index; then hold.
        do_lk(4'b1111, {IDX_W'(3), IDX_W'(3), IDX_W'(0), IDX_W'(7)});
        chk("mc_ch0", ch_data(0), 1024'd9);
        chk("mc_ch1", ch_data(1), 1024'd0);
        chk("mc_ch2", ch_data(2), 1024'd2);
        chk("mc_ch3", ch_data(3), 1024'd2);
        do_lk(4'b0000, '0);
        chk("hold_ch0", ch_data(0), 1024'd9);

        // Rebuild with lookups running; start-cycle lookup sees the old table.
        build(1024'd1, 1024'd13, 1'b1, -1);
        do_lk(4'b0001, {NUM_CH{IDX_W'(7)}});
        chk("rebuild_idx7", ch_data(0), 1024'd7);

        // Stray start mid-GEN is ignored.
        build(1024'd5, 1024'd13, 1'b0, 10);
        do_lk('1, {IDX_W'(3), IDX_W'(2), IDX_W'(1), IDX_W'(7)});

        // Reset in the middle of a build.
        init_base = 1024'd5; init_mod = 1024'd13; init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", init_busy, 1'b0);
        chk("mrst_ready", table_ready, 1'b0);
        chk("mrst_done", init_done, 1'b0);
        chk("mrst_err", init_err, 1'b0);
        chk("mrst_lk_vld", lk_data_valid, '0);
        for (int c = 0; c < NUM_CH; c++) chk("mrst_lk_dat", ch_data(c), '0);
        exp_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) exp_d[c] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_lk('1, LKW'($urandom));
            chk("mrst_ready_stays0", table_ready, 1'b0);
        end
        build(1024'd5, 1024'd13, 1'b0, -1);
        do_lk('1, {IDX_W'(6), IDX_W'(5), IDX_W'(4), IDX_W'(1)});

        // Rejected starts.
        reject(1024'd13, 1024'd13);
        do_lk('1, LKW'($urandom));
        reject(1024'd5, 1024'd0);
        reject(1024'd20, 1024'd13);

        // Full-width random moduli plus the B=0 and B=M-1 boundaries.
        for (int t = 0; t < 5; t++) begin
            for (int w = 0; w < DATA_W / 32; w++) begin
                rm[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            rm[DATA_W-1] = 1'b1;
            rm[0]        = 1'b1;
            if (t == 3)      rb = rm - 1'b1;
            else if (t == 4) rb = '0;
            else             rb = rb % rm;
            full_check(rb, rm);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
